// File: rtl/pc_control.sv
// pc_control: next-PC selection and IF/ID/EX pipeline steering for stalls, instruction-memory waits and redirects.
// State advances on the falling clock edge, in step with the program counter register.
module pc_control #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_cur,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        load_use,
    input  logic        imem_ready,
    output logic [31:0] PC_next,
    output logic        hold,
    output logic        IF_ID_flush,
    output logic        IF_ID_hold,
    output logic        ID_EX_bubble,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, WAIT = 2'b10, BAD = 2'b11} state_t;
    // The first bubble is issued from RUN, so STALL covers the remaining STALL_CYCLES-1
    localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES > 1 ? STALL_CYCLES - 2 : 0);
    state_t      st;
    logic [1:0]  stall_cnt;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        redirect;
    logic        capture;
    logic [31:0] seq_pc;
    logic [31:0] redir_pc;
    assign redirect = jump | branch_taken;
    assign seq_pc   = PC_cur + 32'd4;
    assign redir_pc = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    assign capture  = !imem_ready && redirect && !pend_valid;
    assign state    = st;
    always_comb begin
        PC_next      = PC_cur;
        hold         = 1'b0;
        IF_ID_flush  = 1'b0;
        IF_ID_hold   = 1'b0;
        ID_EX_bubble = 1'b0;
        if (reset) begin
            PC_next     = RESET_VECTOR;
            IF_ID_flush = 1'b1;
        end else if (st == STALL || load_use) begin
            hold         = 1'b1;
            IF_ID_hold   = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (!imem_ready) begin
            hold        = 1'b1;
            IF_ID_flush = 1'b1;
        end else if (st == WAIT) begin
            PC_next     = pend_valid ? pend_target : seq_pc;
            IF_ID_flush = pend_valid;
        end else begin
            PC_next     = redirect ? redir_pc : seq_pc;
            IF_ID_flush = redirect;
        end
    end
    always_ff @(negedge clk) begin
        if (reset) begin
            st          <= RUN;
            stall_cnt   <= 2'd0;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
        end else begin
            case (st)
                RUN: begin
                    if (load_use) begin
                        if (STALL_CYCLES > 1) begin
                            st        <= STALL;
                            stall_cnt <= STALL_INIT;
                        end
                    end else if (!imem_ready) begin
                        st          <= WAIT;
                        pend_valid  <= redirect;
                        pend_target <= redir_pc;
                    end
                end
                STALL: begin
                    if (stall_cnt == 2'd0) st <= RUN;
                    else stall_cnt <= stall_cnt - 2'd1;
                end
                WAIT: begin
                    if (capture) begin
                        pend_valid  <= 1'b1;
                        pend_target <= redir_pc;
                    end else if (imem_ready && !load_use) begin
                        pend_valid <= 1'b0;
                        st         <= RUN;
                    end
                end
                default: st <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: random and directed stimulus against a behavioural model of pc_control.
module tb_pc_control;
    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam int          SC = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic        hold;
        logic        flush;
        logic        ih;
        logic        bub;
        logic [1:0]  st;
    } out_t;

    logic        clk = 1'b1;
    logic        reset = 1'b1;
    logic [31:0] PC_cur = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        load_use = 1'b0;
    logic        imem_ready = 1'b1;
    logic [31:0] PC_next;
    logic        hold, IF_ID_flush, IF_ID_hold, ID_EX_bubble;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    int          stall_left = 0;
    bit          waiting = 1'b0;
    logic [31:0] pend_q[$];
    bit          armed = 1'b0;

    always #5 clk = ~clk;

    pc_control #(.RESET_VECTOR(RV), .STALL_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .PC_cur(PC_cur),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .load_use(load_use), .imem_ready(imem_ready),
        .PC_next(PC_next), .hold(hold), .IF_ID_flush(IF_ID_flush),
        .IF_ID_hold(IF_ID_hold), .ID_EX_bubble(ID_EX_bubble), .state(state)
    );

    function automatic out_t model_out();
        out_t        e;
        logic [31:0] tgt;
        tgt  = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        e    = '0;
        e.pc = PC_cur;
        e.st = stall_left > 0 ? 2'd1 : waiting ? 2'd2 : 2'd0;
        if (reset) begin
            e.pc    = RV;
            e.flush = 1'b1;
        end else if (stall_left > 0 || load_use) begin
            e.hold = 1'b1;
            e.ih   = 1'b1;
            e.bub  = 1'b1;
        end else if (!imem_ready) begin
            e.hold  = 1'b1;
            e.flush = 1'b1;
        end else if (waiting) begin
            e.pc    = pend_q.size() > 0 ? pend_q[0] : PC_cur + 32'd4;
            e.flush = pend_q.size() > 0;
        end else begin
            e.pc    = (jump || branch_taken) ? tgt : PC_cur + 32'd4;
            e.flush = jump || branch_taken;
        end
        return e;
    endfunction

    // Model advances on the same falling edge as the DUT
    always @(negedge clk) begin
        logic [31:0] tgt;
        tgt = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        if (reset) begin
            armed = 1'b1;
            stall_left = 0;
            waiting = 1'b0;
            pend_q.delete();
        end else if (stall_left > 0) begin
            stall_left--;
        end else if (waiting) begin
            if (!imem_ready && (jump || branch_taken) && pend_q.size() == 0) pend_q.push_back(tgt);
            else if (imem_ready && !load_use) begin
                waiting = 1'b0;
                pend_q.delete();
            end
        end else if (load_use) begin
            stall_left = SC - 1;
        end else if (!imem_ready) begin
            waiting = 1'b1;
            if (jump || branch_taken) pend_q.push_back(tgt);
        end
    end

    always @(posedge clk) begin
        if (armed) begin
            out_t e, g;
            e = model_out();
            g = {PC_next, hold, IF_ID_flush, IF_ID_hold, ID_EX_bubble, state};
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL model t=%0t got pc=%h h/f/ih/b=%b st=%0d want pc=%h h/f/ih/b=%b st=%0d",
                         $time, g.pc, {g.hold, g.flush, g.ih, g.bub}, g.st,
                         e.pc, {e.hold, e.flush, e.ih, e.bub}, e.st);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [31:0] pc, input logic lu, input logic im,
                       input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
        @(negedge clk);
        #1;
        reset = r; PC_cur = pc; load_use = lu; imem_ready = im;
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
        #1;
    endtask

    function automatic logic [31:0] ctl();
        return {28'd0, hold, IF_ID_flush, IF_ID_hold, ID_EX_bubble};
    endfunction

    initial begin
        cyc(1, 32'h55, 1, 1, 1, 32'h40, 1, 32'h80);
        chk("rst_pc", PC_next, RV);
        chk("rst_ctl", ctl(), 32'b0100);
        cyc(0, 32'h10, 0, 1, 0, 0, 0, 0);
        chk("seq_pc", PC_next, 32'h14);
        chk("seq_ctl", ctl(), 32'b0000);
        chk("seq_state", {30'd0, state}, 32'd0);
        cyc(0, 32'hFFFF_FFFC, 0, 1, 0, 0, 0, 0);
        chk("wrap_pc", PC_next, 32'h0);
        cyc(0, 32'h20, 0, 1, 1, 32'h40, 1, 32'h80);
        chk("jump_pri_pc", PC_next, 32'h40);
        chk("jump_pri_ctl", ctl(), 32'b0100);
        cyc(0, 32'h40, 0, 1, 0, 0, 0, 0);
        chk("after_jump_ctl", ctl(), 32'b0000);
        cyc(0, 32'h100, 1, 1, 0, 0, 0, 0);
        chk("lu_ctl", ctl(), 32'b1011);
        chk("lu_pc", PC_next, 32'h100);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 32'h100, 0, 1, 0, 0, 0, 0);
            chk("stall_ctl", ctl(), 32'b1011);
            chk("stall_state", {30'd0, state}, 32'd1);
        end
        cyc(0, 32'h100, 0, 1, 0, 0, 0, 0);
        chk("post_stall_ctl", ctl(), 32'b0000);
        chk("post_stall_pc", PC_next, 32'h104);
        cyc(0, 32'h200, 0, 0, 0, 0, 1, 32'h123);
        chk("wait1_ctl", ctl(), 32'b1100);
        cyc(0, 32'h200, 0, 0, 1, 32'h200, 0, 0);
        chk("wait2_ctl", ctl(), 32'b1100);
        chk("wait2_state", {30'd0, state}, 32'd2);
        cyc(0, 32'h200, 0, 0, 0, 0, 0, 0);
        chk("wait3_ctl", ctl(), 32'b1100);
        cyc(0, 32'h200, 0, 1, 0, 0, 0, 0);
        chk("pend_pc", PC_next, 32'h120);
        chk("pend_ctl", ctl(), 32'b0100);
        cyc(0, 32'h120, 0, 1, 0, 0, 0, 0);
        chk("pend_done_state", {30'd0, state}, 32'd0);
        chk("pend_done_pc", PC_next, 32'h124);
        cyc(0, 32'h300, 1, 1, 0, 0, 0, 0);
        cyc(0, 32'h300, 0, 1, 0, 0, 0, 0);
        chk("s1_state", {30'd0, state}, 32'd1);
        cyc(1, 32'h300, 0, 1, 0, 0, 0, 0);
        chk("rst_stall_pc", PC_next, RV);
        cyc(0, 32'h300, 0, 1, 0, 0, 0, 0);
        chk("rst_stall_state", {30'd0, state}, 32'd0);
        chk("rst_stall_ctl", ctl(), 32'b0000);
        chk("rst_stall_pc2", PC_next, 32'h304);
        cyc(0, 32'h400, 1, 1, 1, 32'h44, 0, 0);
        chk("lu_jump_pc", PC_next, 32'h400);
        chk("lu_jump_ctl", ctl(), 32'b1011);
        cyc(0, 32'h400, 0, 1, 0, 0, 0, 0);
        cyc(0, 32'h400, 0, 1, 0, 0, 0, 0);
        cyc(0, 32'h400, 0, 1, 1, 32'h44, 0, 0);
        chk("rejump_pc", PC_next, 32'h44);
        chk("rejump_ctl", ctl(), 32'b0100);
        cyc(0, 32'h500, 0, 1, 0, 0, 1, 32'h87);
        chk("br_mask_pc", PC_next, 32'h84);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 49) == 0, $urandom, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, $urandom,
                $urandom_range(0, 4) == 0, $urandom);
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value presented on PC_next while reset is high.
REQ-002 Parameter STALL_CYCLES, default 1: bubbles per load-use hazard; legal range 1..3.
REQ-003 clk  input  1  single clock; all state updates on the falling edge of clk, same edge as the program counter.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PC_cur  input  32  current program counter output.
REQ-006 branch_taken  input  1  ID-stage branch resolved taken.
REQ-007 branch_target  input  32  branch destination.
REQ-008 jump  input  1  ID-stage unconditional jump.
REQ-009 jump_target  input  32  jump destination.
REQ-010 load_use  input  1  hazard-detect load-use request.
REQ-011 imem_ready  input  1  instruction memory returns valid data for PC_cur this cycle.
REQ-012 PC_next  output  32  value for program counter PC_in.
REQ-013 hold  output  1  program counter hold.
REQ-014 IF_ID_flush  output  1  IF/ID register loads a bubble.
REQ-015 IF_ID_hold  output  1  IF/ID register keeps its contents.
REQ-016 ID_EX_bubble  output  1  ID/EX register loads a bubble.
REQ-017 state  output  2  current state encoding, debug only.

Function
REQ-018 States: RUN=2'b00, STALL=2'b01, WAIT=2'b10; encoding 2'b11 SHALL go to RUN on the next edge, outputs as RUN.
REQ-019 Registered state: state, stall_cnt (2 bits), pend_valid, pend_target (32 bits); all outputs combinational from these and the inputs (Mealy).
REQ-020 Sequential PC = PC_cur + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0); redirect targets SHALL have bits [1:0] forced to 0.
REQ-021 RUN priority, highest first: load_use > imem_ready=0 > jump > branch_taken > sequential.
REQ-022 RUN, load_use=1: hold=1, IF_ID_hold=1, ID_EX_bubble=1, redirects ignored; if STALL_CYCLES>1 go STALL with stall_cnt=STALL_CYCLES-2, else stay RUN.
REQ-023 RUN, load_use=0, imem_ready=0: hold=1, IF_ID_flush=1; go WAIT; if jump or branch_taken, capture its target (jump preferred) into pend_target and set pend_valid.
REQ-024 RUN, imem_ready=1, jump=1: PC_next=jump_target, IF_ID_flush=1, hold=0.
REQ-025 RUN, imem_ready=1, branch_taken=1, jump=0: PC_next=branch_target, IF_ID_flush=1, hold=0.
REQ-026 RUN, no event: PC_next=PC_cur+4, all control outputs 0.
REQ-027 STALL: hold=1, IF_ID_hold=1, ID_EX_bubble=1, redirects and imem_ready ignored; stall_cnt decrements each edge; at stall_cnt==0 the next edge goes to RUN.
REQ-028 WAIT, imem_ready=0: hold=1, IF_ID_flush=1; a redirect captured only when pend_valid=0; later redirects ignored.
REQ-029 WAIT, load_use=1: additionally IF_ID_hold=1, ID_EX_bubble=1; IF_ID_hold overrides IF_ID_flush; state unchanged.
REQ-030 WAIT, imem_ready=1: hold=0; PC_next=pend_target and IF_ID_flush=1 if pend_valid, else PC_next=PC_cur+4 and IF_ID_flush=0; clear pend_valid; go RUN.
REQ-031 Whenever hold=1, PC_next SHALL equal PC_cur.
REQ-032 load_use together with jump/branch in RUN: no redirect that cycle; the redirect is taken when ID re-presents it after the stall.

Reset
REQ-033 reset=1 at a falling edge: state=RUN, stall_cnt=0, pend_valid=0, pend_target=0.
REQ-034 While reset=1: PC_next=RESET_VECTOR, hold=0, IF_ID_flush=1, IF_ID_hold=0, ID_EX_bubble=0, regardless of other inputs.
REQ-035 Reset mid-STALL or mid-WAIT SHALL discard remaining bubbles and any pending redirect; first cycle after reset is RUN with sequential fetch.

Verification
REQ-036 PC_cur=32'h0000_0010, imem_ready=1, no events -> PC_next=32'h14, all controls 0; PC_cur=32'hFFFF_FFFC -> PC_next=32'h0.
REQ-037 STALL_CYCLES=3, load_use pulse 1 cycle -> hold/IF_ID_hold/ID_EX_bubble high exactly 3 cycles, state RUN->STALL->STALL->RUN.
REQ-038 jump=1 (jump_target=32'h40) with branch_taken=1 (branch_target=32'h80) -> PC_next=32'h40, IF_ID_flush=1 for one cycle.
REQ-039 imem_ready low 3 cycles, branch_taken (target 32'h0000_0123) in first, jump (target 32'h200) in second -> hold 3 cycles, then PC_next=32'h120, IF_ID_flush=1, state RUN.
REQ-040 reset asserted during second STALL cycle with STALL_CYCLES=3 -> PC_next=RESET_VECTOR, next cycle state=RUN, hold=0.
REQ-041 load_use and jump same cycle -> no redirect, bubble inserted; jump re-asserted next cycle -> PC_next=jump_target.
